// File: rtl/apb_requester.sv
// ----------------------------------------------------------------------------
// apb_requester
//
// APB3 requester for the I2C bridge register block (TX FIFO 0x0, RX FIFO 0x4,
// CONFIG 0x8, TIMEOUT 0xC). A single command token on the CMD_* handshake
// becomes one APB SETUP/ACCESS transfer. The outcome comes back on the RSP_*
// handshake: read data, slave error and timeout status. Only one transfer
// is outstanding at a time.
//
// Ports
//   PCLK, PRESET         clock (rising edge) and synchronous active-high reset
//   CMD_VALID/CMD_READY  command handshake
//   CMD_WRITE            1 = write, 0 = read
//   CMD_ADDR, CMD_WDATA  target address and write data
//   RSP_VALID/RSP_READY  response handshake
//   RSP_RDATA            read data (0 for writes and timeouts)
//   RSP_ERR              PSLVERR seen or transfer timed out
//   RSP_TIMEOUT          transfer aborted because PREADY never came
//   PSELx, PENABLE,
//   PWRITE, PADDR,
//   PWDATA               APB request outputs (all registered)
//   PRDATA, PREADY,
//   PSLVERR              APB completer inputs
// ----------------------------------------------------------------------------
module apb_requester #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // A zero TIMEOUT_CYC still needs a one-bit counter to keep the code legal.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Saturating increment: the wait counter sticks at all-ones instead of
    // wrapping, which matters when timeouts are disabled.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Abort only in the ACCESS cycle whose wait count reaches the limit and
    // where PREADY is still low; a late PREADY in that cycle still wins.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            CMD_READY   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Command fields are latched straight onto the bus
                    // registers; they then hold until the next command.
                    if (CMD_VALID) begin
                        PWRITE    <= CMD_WRITE;
                        PADDR     <= CMD_ADDR;
                        PWDATA    <= CMD_WDATA;
                        PSELx     <= 1'b1;
                        CMD_READY <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        RSP_RDATA   <= PWRITE ? '0 : PRDATA;
                        RSP_ERR     <= PSLVERR;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timeout_hit) begin
                        RSP_RDATA   <= '0;
                        RSP_ERR     <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end

                ST_RESP: begin
                    // CMD_READY returns only with IDLE, so a command held
                    // during RESP is taken one cycle after the handshake.
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Protocol invariants of the requester side.
    a_pen_needs_sel: assert property (@(posedge PCLK) disable iff (PRESET)
        PENABLE |-> PSELx);

    a_rsp_stable: assert property (@(posedge PCLK) disable iff (PRESET)
        (RSP_VALID && !RSP_READY) |=>
        (RSP_VALID && $stable(RSP_RDATA) && $stable(RSP_ERR) && $stable(RSP_TIMEOUT)));

    a_one_outstanding: assert property (@(posedge PCLK) disable iff (PRESET)
        CMD_READY |-> (!PSELx && !RSP_VALID));

endmodule

// File: tb/tb_apb_requester.sv
// ----------------------------------------------------------------------------
// tb_apb_requester
//
// Drives command tokens into apb_requester, plays the APB completer with a
// programmable number of wait states, and compares the response, latency
// and bus activity with values derived from the transfer rules.
// ----------------------------------------------------------------------------
module tb_apb_requester;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 16;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              CMD_VALID = 1'b0;
    logic              CMD_READY;
    logic              CMD_WRITE = 1'b0;
    logic [ADDR_W-1:0] CMD_ADDR = '0;
    logic [DATA_W-1:0] CMD_WDATA = '0;
    logic              RSP_VALID;
    logic              RSP_READY = 1'b0;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic              RSP_TIMEOUT;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;
    logic              PSLVERR = 1'b0;

    apb_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations recorded by run_xfer for the calling test to judge.
    logic        o_ready_start;
    int          o_lat;
    int          o_psel;
    int          o_pen;
    bit          o_bus_bad;
    bit          o_pen_wo_sel;
    bit          o_busy_bad;
    bit          o_rsp_unstable;
    logic        o_psel_at_rsp;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_to;
    logic        o_ready_after;
    logic        o_valid_after;
    logic [31:0] o_paddr_after;
    logic        o_pwrite_after;

    // One complete transfer. 'waits' is the number of PREADY=0 ACCESS cycles
    // the completer inserts; 'hold' is how many cycles RSP_READY stays low
    // after RSP_VALID appears; 'keep_valid' keeps CMD_VALID asserted.
    task automatic run_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits,
                            input logic [31:0] rdata, input logic slverr,
                            input int hold, input bit keep_valid);
        int n;
        int acc;
        bit got;
        o_psel = 0; o_pen = 0; o_bus_bad = 0; o_pen_wo_sel = 0;
        o_busy_bad = 0; o_rsp_unstable = 0; o_lat = -1; o_psel_at_rsp = 1'bx;
        o_rdata = 'x; o_err = 1'bx; o_to = 1'bx;
        o_ready_start = CMD_READY;
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
        PREADY = 1'b0; RSP_READY = 1'b0;
        n = 0; acc = 0; got = 0;
        while (!got && n < 100) begin
            @(posedge PCLK); #1; n++;
            if (!keep_valid) begin
                // Scramble the command inputs so only latched values can match.
                CMD_VALID = 1'b0; CMD_WRITE = ~wr; CMD_ADDR = ~addr; CMD_WDATA = ~wdata;
            end
            if (RSP_VALID === 1'b1) begin
                got = 1; o_lat = n; o_psel_at_rsp = PSELx;
                o_rdata = RSP_RDATA; o_err = RSP_ERR; o_to = RSP_TIMEOUT;
                PREADY = 1'b0; PSLVERR = 1'b0;
            end else begin
                if (CMD_READY !== 1'b0) o_busy_bad = 1;
                if (PSELx === 1'b1) o_psel++;
                if (PENABLE === 1'b1) o_pen++;
                if (PENABLE === 1'b1 && PSELx !== 1'b1) o_pen_wo_sel = 1;
                if (PSELx === 1'b1 && (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata))
                    o_bus_bad = 1;
                if (PSELx === 1'b1 && PENABLE === 1'b1) begin
                    PREADY  = (acc == waits);
                    PRDATA  = (acc == waits) ? rdata : $urandom;
                    PSLVERR = (acc == waits) ? slverr : 1'($urandom);
                    acc++;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
            end
        end
        if (!got) begin
            $display("FAIL xfer_bound: no RSP_VALID within 100 cycles, expected one");
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge PCLK); #1;
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== o_rdata || RSP_ERR !== o_err ||
                RSP_TIMEOUT !== o_to)
                o_rsp_unstable = 1;
            if (CMD_READY !== 1'b0 || PSELx !== 1'b0) o_busy_bad = 1;
        end
        RSP_READY = 1'b1;
        @(posedge PCLK); #1;
        RSP_READY = 1'b0;
        o_ready_after = CMD_READY; o_valid_after = RSP_VALID;
        o_paddr_after = PADDR; o_pwrite_after = PWRITE;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge PCLK);
        #1;
        n_checks++; if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", CMD_READY); end
        n_checks++; if (PSELx !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b expected 0", PSELx); end
        n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b expected 0", PENABLE); end
        n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", RSP_VALID); end
        n_checks++; if ({RSP_ERR, RSP_TIMEOUT, PWRITE} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {RSP_ERR, RSP_TIMEOUT, PWRITE}); end
        n_checks++; if (RSP_RDATA !== 32'h0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_data: rdata %h paddr %h pwdata %h expected all 0", RSP_RDATA, PADDR, PWDATA); end
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        n_checks++; if (CMD_READY !== 1'b1 || PSELx !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: cmd_ready %b psel %b expected 1/0", CMD_READY, PSELx); end
    endtask

    task automatic test_write_basic();
        run_xfer(1'b1, 32'h0, 32'hA5, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
        n_checks++; if (o_ready_start !== 1'b1) begin n_fail++; $display("FAIL wr_ready_start: got %b expected 1", o_ready_start); end
        n_checks++; if (o_lat != 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", o_lat); end
        n_checks++; if (o_psel != 2) begin n_fail++; $display("FAIL wr_psel_cycles: got %0d expected 2", o_psel); end
        n_checks++; if (o_pen != 1) begin n_fail++; $display("FAIL wr_penable_cycles: got %0d expected 1", o_pen); end
        n_checks++; if (o_bus_bad) begin n_fail++; $display("FAIL wr_bus_fields: got mismatch expected PADDR=0 PWRITE=1 PWDATA=a5"); end
        n_checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0 || o_to !== 1'b0) begin n_fail++; $display("FAIL wr_rsp: got rdata %h err %b to %b expected 0/0/0", o_rdata, o_err, o_to); end
        n_checks++; if (o_pen_wo_sel || o_busy_bad) begin n_fail++; $display("FAIL wr_protocol: got pen_wo_sel %b busy %b expected 0/0", o_pen_wo_sel, o_busy_bad); end
        n_checks++; if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0) begin n_fail++; $display("FAIL wr_after: got ready %b valid %b expected 1/0", o_ready_after, o_valid_after); end
    endtask

    task automatic test_read_wait();
        run_xfer(1'b0, 32'h4, 32'h0BAD_F00D, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        n_checks++; if (o_pen != 4) begin n_fail++; $display("FAIL rd_access_cycles: got %0d expected 4", o_pen); end
        n_checks++; if (o_lat != 6) begin n_fail++; $display("FAIL rd_latency: got %0d expected 6", o_lat); end
        n_checks++; if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got %h err %b expected deadbeef/0", o_rdata, o_err); end
        n_checks++; if (o_bus_bad) begin n_fail++; $display("FAIL rd_bus_fields: got change during wait states expected stable"); end
        n_checks++; if (o_paddr_after !== 32'h4 || o_pwrite_after !== 1'b0) begin n_fail++; $display("FAIL rd_hold_after: got paddr %h pwrite %b expected 4/0", o_paddr_after, o_pwrite_after); end
    endtask

    task automatic test_slverr();
        run_xfer(1'b1, 32'h8, 32'h0000_0003, 1, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        n_checks++; if (o_err !== 1'b1 || o_to !== 1'b0) begin n_fail++; $display("FAIL slverr_rsp: got err %b to %b expected 1/0", o_err, o_to); end
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL slverr_rdata: got %h expected 0", o_rdata); end
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 32'h20, 32'h0, 1000, 32'h5555_5555, 1'b0, 0, 1'b0);
        n_checks++; if (o_pen != TO) begin n_fail++; $display("FAIL to_access_cycles: got %0d expected %0d", o_pen, TO); end
        n_checks++; if (o_lat != TO + 2) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", o_lat, TO + 2); end
        n_checks++; if (o_err !== 1'b1 || o_to !== 1'b1 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rsp: got err %b to %b rdata %h expected 1/1/0", o_err, o_to, o_rdata); end
        n_checks++; if (o_psel_at_rsp !== 1'b0) begin n_fail++; $display("FAIL to_psel_drop: got %b expected 0", o_psel_at_rsp); end
        // Last-chance PREADY in the final allowed cycle is a normal completion.
        run_xfer(1'b0, 32'h4, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0, 0, 1'b0);
        n_checks++; if (o_to !== 1'b0 || o_rdata !== 32'hCAFE_0001 || o_pen != TO) begin n_fail++; $display("FAIL to_edge_ready: got to %b rdata %h access %0d expected 0/cafe0001/%0d", o_to, o_rdata, o_pen, TO); end
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b0, 32'hC, 32'h0, 1, 32'h0000_00C3, 1'b0, 5, 1'b1);
        n_checks++; if (o_rsp_unstable) begin n_fail++; $display("FAIL bp_rsp_stable: got change while RSP_READY=0 expected stable"); end
        n_checks++; if (o_busy_bad) begin n_fail++; $display("FAIL bp_busy: got CMD_READY or PSELx during RESP expected 0"); end
        n_checks++; if (o_rdata !== 32'h0000_00C3) begin n_fail++; $display("FAIL bp_rdata: got %h expected c3", o_rdata); end
        n_checks++; if (o_ready_after !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b expected 1", o_ready_after); end
        run_xfer(1'b1, 32'h0, 32'h0000_005A, 0, 32'h0, 1'b0, 0, 1'b0);
        n_checks++; if (o_ready_start !== 1'b1 || o_lat != 3) begin n_fail++; $display("FAIL bp_next_accept: got ready %b latency %0d expected 1/3", o_ready_start, o_lat); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0; CMD_WDATA = 32'h77;
        PREADY = 1'b0; RSP_READY = 1'b1;
        @(posedge PCLK); #1; CMD_VALID = 1'b0;
        @(posedge PCLK); #1;
        n_checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b1) begin n_fail++; $display("FAIL rm_in_access: got psel %b pen %b expected 1/1", PSELx, PENABLE); end
        PRESET = 1'b1; PREADY = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        n_checks++; if (PSELx !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL rm_bus_drop: got psel %b pen %b expected 0/0", PSELx, PENABLE); end
        n_checks++; if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl: got ready %b valid %b expected 1/0", CMD_READY, RSP_VALID); end
        bad = 0;
        repeat (4) begin
            @(posedge PCLK); #1;
            if (RSP_VALID !== 1'b0 || PSELx !== 1'b0) bad = 1;
        end
        PREADY = 1'b0; RSP_READY = 1'b0;
        n_checks++; if (bad) begin n_fail++; $display("FAIL rm_discarded: got activity after reset expected none"); end
        run_xfer(1'b0, 32'h4, 32'h0, 0, 32'h1357_9BDF, 1'b0, 0, 1'b0);
        n_checks++; if (o_lat != 3 || o_rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rm_recover: got latency %0d rdata %h expected 3/13579bdf", o_lat, o_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] addrs [5];
        for (int it = 0; it < 30; it++) begin
            logic        wr, se, exp_to, exp_err;
            logic [31:0] ad, wd, rd, exp_rd;
            int          waits, hold, acc_cyc;
            addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
            addrs[4] = $urandom;
            wr = 1'($urandom); se = 1'($urandom_range(0, 3) == 0);
            ad = addrs[$urandom_range(0, 4)]; wd = $urandom; rd = $urandom;
            waits = $urandom_range(0, 20); hold = $urandom_range(0, 3);
            // Expected outcome from the transfer rules.
            exp_to  = (waits >= TO);
            exp_err = exp_to | se;
            exp_rd  = (exp_to || wr) ? 32'h0 : rd;
            acc_cyc = exp_to ? TO : waits + 1;
            run_xfer(wr, ad, wd, waits, rd, se, hold, 1'b0);
            n_checks++; if (o_lat != acc_cyc + 2 || o_pen != acc_cyc || o_psel != acc_cyc + 1) begin n_fail++; $display("FAIL rnd_timing[%0d]: got lat %0d pen %0d psel %0d expected %0d/%0d/%0d", it, o_lat, o_pen, o_psel, acc_cyc + 2, acc_cyc, acc_cyc + 1); end
            n_checks++; if (o_rdata !== exp_rd || o_err !== exp_err || o_to !== exp_to) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got %h/%b/%b expected %h/%b/%b", it, o_rdata, o_err, o_to, exp_rd, exp_err, exp_to); end
            n_checks++; if (o_bus_bad || o_pen_wo_sel || o_busy_bad || o_rsp_unstable) begin n_fail++; $display("FAIL rnd_protocol[%0d]: got bus %b pen %b busy %b unstable %b expected 0", it, o_bus_bad, o_pen_wo_sel, o_busy_bad, o_rsp_unstable); end
            n_checks++; if (o_paddr_after !== ad || o_pwrite_after !== wr || o_ready_after !== 1'b1) begin n_fail++; $display("FAIL rnd_after[%0d]: got paddr %h pwrite %b ready %b expected %h/%b/1", it, o_paddr_after, o_pwrite_after, o_ready_after, ad, wr); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
